// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: hazard stalls/flushes,
// operand forwarding selects, and a data-memory handshake with timeout watchdog.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic [4:0]       writeRegM,
    input  logic [4:0]       writeRegW,
    input  logic             Regfile_weE,
    input  logic             Regfile_weM,
    input  logic             Regfile_weW,
    input  logic             memReadE,
    input  logic             memReadM,
    input  logic             branchD,
    input  logic             redirectD,
    input  logic             memAccessM,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [1:0] fae, fbe;
    logic       fad, fbd, lwstall, brstall, hz, freeze, req, sfd;

    // A write to register 0 never creates a dependency.
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        fae = hit(Regfile_weM, writeRegM, rsE) ? 2'b10 :
              hit(Regfile_weW, writeRegW, rsE) ? 2'b01 : 2'b00;
        fbe = hit(Regfile_weM, writeRegM, rtE) ? 2'b10 :
              hit(Regfile_weW, writeRegW, rtE) ? 2'b01 : 2'b00;
        fad = hit(Regfile_weM, writeRegM, rsD);
        fbd = hit(Regfile_weM, writeRegM, rtD);
        lwstall = hit(memReadE, writeRegE, rsD) | hit(memReadE, writeRegE, rtD);
        brstall = branchD & (hit(Regfile_weE, writeRegE, rsD) | hit(Regfile_weE, writeRegE, rtD) |
                             hit(memReadM, writeRegM, rsD) | hit(memReadM, writeRegM, rtD));
        hz = lwstall | brstall;
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        freeze    = 1'b0;
        req       = 1'b0;
        case (state_q)
            RUN: begin
                req = memAccessM;
                if (memAccessM && !dmem_ready) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    freeze  = 1'b1;
                    req     = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WC_W'(MEM_TIMEOUT)) begin
                    // Abort: unfreeze so the pipeline moves past the dead access.
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end else begin
                    freeze = 1'b1;
                    req    = 1'b1;
                    wait_d = wait_q + WC_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
        sfd = freeze | hz;
        stall_cnt_d = (sfd && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Every output is held low while reset is asserted.
    assign stallF    = rst & sfd;
    assign stallD    = rst & sfd;
    assign stallE    = rst & freeze;
    assign stallM    = rst & freeze;
    assign flushW    = rst & freeze;
    assign flushE    = rst & hz & ~freeze;
    assign flushD    = rst & redirectD & ~sfd;
    assign dmem_req  = rst & req;
    assign forwardAE = rst ? fae : 2'b00;
    assign forwardBE = rst ? fbe : 2'b00;
    assign forwardAD = rst & fad;
    assign forwardBD = rst & fbd;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle hazard/forwarding vectors
// plus hand-written memory-wait, timeout and async-reset sequences.
module tb_hazard_ctrl;
    logic        clk, rst;
    logic [4:0]  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic        Regfile_weE, Regfile_weM, Regfile_weW, memReadE, memReadM;
    logic        branchD, redirectD, memAccessM, dmem_ready;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  forwardAE, forwardBE;
    logic        forwardAD, forwardBD, dmem_req, mem_err;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
        .memReadE(memReadE), .memReadM(memReadM), .branchD(branchD), .redirectD(redirectD),
        .memAccessM(memAccessM), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rsD, rtD, rsE, rtE, wE, wM, wW;
        int weE, weM, weW, mrE, mrM, brD, rdD;
        int fAE, fBE, fAD, fBD, sF, sD, fD, fE;
        string nm;
    } vec_t;

    function automatic logic [13:0] pk(input int fae, input int fbe, input int fad, input int fbd,
                                       input int sf, input int sd, input int se, input int sm,
                                       input int fd, input int fe, input int fw, input int rq);
        return {2'(fae), 2'(fbe), 1'(fad), 1'(fbd), 1'(sf), 1'(sd), 1'(se), 1'(sm),
                1'(fd), 1'(fe), 1'(fw), 1'(rq)};
    endfunction

    function automatic logic [13:0] outs();
        return {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, stallM,
                flushD, flushE, flushW, dmem_req};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic zero_in();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
        Regfile_weE = 0; Regfile_weM = 0; Regfile_weW = 0; memReadE = 0; memReadM = 0;
        branchD = 0; redirectD = 0; memAccessM = 0; dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [13:0] FREEZE = 14'b00_00_0_0_1111_0011;
    localparam logic [13:0] IDLE   = 14'd0;

    vec_t vt[12];

    initial begin
        vt[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, "idle"};
        vt[1]  = '{2,0,0,0,2,0,0, 1,0,0,1,0,0,0, 0,0,0,0,1,1,0,1, "load_use"};
        vt[2]  = '{0,0,2,0,0,0,2, 0,0,1,0,0,0,0, 1,0,0,0,0,0,0,0, "lu_fwd_wb"};
        vt[3]  = '{0,0,5,0,0,5,5, 0,1,1,0,0,0,0, 2,0,0,0,0,0,0,0, "fwd_prio"};
        vt[4]  = '{0,0,0,0,0,0,0, 0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0, "fwd_r0"};
        vt[5]  = '{0,0,0,7,0,0,7, 0,0,1,0,0,0,0, 0,1,0,0,0,0,0,0, "fwdB_wb"};
        vt[6]  = '{3,0,0,0,3,0,0, 1,0,0,0,0,1,1, 0,0,0,0,1,1,0,1, "br_ex"};
        vt[7]  = '{3,0,0,0,0,3,0, 0,1,0,0,0,1,1, 0,0,1,0,0,0,1,0, "br_fwd_mem"};
        vt[8]  = '{0,4,0,0,0,4,0, 0,1,0,0,1,1,0, 0,0,0,1,1,1,0,1, "br_load_mem"};
        vt[9]  = '{0,0,0,0,0,0,0, 1,0,0,1,0,1,0, 0,0,0,0,0,0,0,0, "r0_nohaz"};
        vt[10] = '{0,9,0,0,9,0,0, 1,0,0,1,0,0,1, 0,0,0,0,1,1,0,1, "lu_rt_redir"};
        vt[11] = '{0,0,6,0,0,6,6, 0,0,1,0,0,0,0, 1,0,0,0,0,0,0,0, "weM_off"};

        // Reset: outputs forced low even with a forwarding match present.
        rst = 1'b0;
        zero_in();
        rsE = 5; writeRegM = 5; Regfile_weM = 1;
        #12;
        chk("rst_outs", 32'(outs()), 32'(IDLE));
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_err", 32'(mem_err), 0);
        rst = 1'b1;
        zero_in();
        tick();

        for (int i = 0; i < 12; i++) begin
            rsD = 5'(vt[i].rsD); rtD = 5'(vt[i].rtD); rsE = 5'(vt[i].rsE); rtE = 5'(vt[i].rtE);
            writeRegE = 5'(vt[i].wE); writeRegM = 5'(vt[i].wM); writeRegW = 5'(vt[i].wW);
            Regfile_weE = 1'(vt[i].weE); Regfile_weM = 1'(vt[i].weM); Regfile_weW = 1'(vt[i].weW);
            memReadE = 1'(vt[i].mrE); memReadM = 1'(vt[i].mrM);
            branchD = 1'(vt[i].brD); redirectD = 1'(vt[i].rdD);
            #3;
            chk(vt[i].nm, 32'(outs()), 32'(pk(vt[i].fAE, vt[i].fBE, vt[i].fAD, vt[i].fBD,
                vt[i].sF, vt[i].sD, 0, 0, vt[i].fD, vt[i].fE, 0, 0)));
            exp_cnt += vt[i].sF;
            tick();
        end
        zero_in();
        #3;
        chk("cnt_after_table", 32'(stall_cnt), 32'(exp_cnt));
        tick();

        // Memory wait: ready low 3 cycles then high; hazard and redirect are overridden.
        memAccessM = 1; redirectD = 1;
        memReadE = 1; Regfile_weE = 1; writeRegE = 2; rsD = 2;
        for (int c = 0; c < 4; c++) begin
            dmem_ready = (c == 3);
            #3;
            chk($sformatf("memwait_c%0d", c), 32'(outs()), 32'(FREEZE));
            tick();
        end
        zero_in();
        exp_cnt += 4;
        #3;
        chk("memwait_done", 32'(outs()), 32'(IDLE));
        chk("memwait_cnt", 32'(stall_cnt), 32'(exp_cnt));
        chk("memwait_err", 32'(mem_err), 0);
        tick();

        // dmem_ready with no access is ignored.
        dmem_ready = 1;
        #3;
        chk("ready_idle", 32'(outs()), 32'(IDLE));
        tick();

        // Zero-wait access: request only, no stall.
        memAccessM = 1; dmem_ready = 1;
        #3;
        chk("zero_wait", 32'(outs()), 32'(pk(0,0,0,0, 0,0,0,0, 0,0,0,1)));
        tick();
        zero_in();
        #3;
        chk("zero_wait_after", 32'(outs()), 32'(IDLE));
        chk("zero_wait_cnt", 32'(stall_cnt), 32'(exp_cnt));
        tick();

        // Timeout with MEM_TIMEOUT=4: four frozen cycles, then released and error latched.
        memAccessM = 1; dmem_ready = 0;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("tmo_c%0d", c), 32'(outs()), 32'(FREEZE));
            tick();
        end
        #3;
        chk("tmo_err_pre", 32'(mem_err), 0);
        chk("tmo_release", 32'(outs()), 32'(IDLE));
        tick();
        exp_cnt += 4;
        memAccessM = 0;
        #3;
        chk("tmo_err_set", 32'(mem_err), 1);
        chk("tmo_cnt", 32'(stall_cnt), 32'(exp_cnt));
        tick();
        tick();
        chk("tmo_err_sticky", 32'(mem_err), 1);

        // Async reset in the middle of a wait.
        memAccessM = 1; dmem_ready = 0;
        tick();
        #1;
        chk("pre_rst_freeze", 32'(outs()), 32'(FREEZE));
        rsE = 5; writeRegM = 5; Regfile_weM = 1;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'(IDLE));
        chk("async_rst_cnt", 32'(stall_cnt), 0);
        chk("async_rst_err", 32'(mem_err), 0);
        zero_in();
        @(negedge clk);
        rst = 1'b1;
        tick();
        memAccessM = 1; dmem_ready = 1;
        #3;
        chk("post_rst_run", 32'(outs()), 32'(pk(0,0,0,0, 0,0,0,0, 0,0,0,1)));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It sits beside the decoder (control_unit) and the IF/ID/EX/MEM/WB pipeline registers. It generates per-stage stall/flush, the EX and ID forwarding selects, and a data-memory req/ready handshake with a timeout watchdog. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for dmem_ready before the access is aborted (≥2).
CNT_W, 16, width of stall_cnt.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
rsD, rtD  in  5 each  source registers of the instruction in ID.
rsE, rtE  in  5 each  source registers of the instruction in EX.
writeRegE, writeRegM, writeRegW  in  5 each  destination register per stage.
Regfile_weE, Regfile_weM, Regfile_weW  in  1 each  register-write enable per stage.
memReadE, memReadM  in  1 each  the instruction in that stage is a load.
branchD  in  1  the ID instruction reads registers for its next-PC decision (beq/bne/jr).
redirectD  in  1  the next PC is not PC+4 (taken branch, j, jal, jr).
memAccessM  in  1  the MEM instruction is a load or store.
dmem_ready  in  1  data memory has completed the current access.
stallF, stallD, stallE, stallM  out  1 each  hold the stage register.
flushD, flushE, flushW  out  1 each  load a bubble into the stage register.
forwardAE, forwardBE  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result.
forwardAD, forwardBD  out  1 each  ID comparator operand taken from the MEM ALU result.
dmem_req  out  1  data-memory access request.
mem_err  out  1  sticky flag: an access timed out.
stall_cnt  out  CNT_W  saturating count of cycles with stallF=1.

Behaviour:
- Reset (rst=0, asynchronous): state←RUN, wait counter←0, mem_err←0, stall_cnt←0. All outputs are forced to 0 while rst=0. A reset during MEM_WAIT abandons the access and drops dmem_req immediately.
- Register 0 is never a hazard and is never forwarded. Every match term requires a nonzero destination register.
- Forwarding (combinational, all states):
  - forwardAE=10 if Regfile_weM & writeRegM==rsE; else 01 if Regfile_weW & writeRegW==rsE; else 00. The MEM stage has priority. forwardBE is the same with rtE.
  - forwardAD = Regfile_weM & writeRegM==rsD. forwardBD is the same with rtD.
- FSM states: RUN and MEM_WAIT.
- RUN:
  - dmem_req = memAccessM.
  - If memAccessM & !dmem_ready: next state is MEM_WAIT with the wait counter←1. The stall outputs apply in this same cycle.
  - lwstall = memReadE & writeRegE matches rsD or rtD.
  - brstall = branchD & ((Regfile_weE & writeRegE matches rsD/rtD) | (memReadM & writeRegM matches rsD/rtD)).
  - If lwstall|brstall: stallF=stallD=1, flushE=1.
  - flushD = redirectD & !stallD.
- MEM_WAIT, and the RUN cycle that enters it:
  - stallF=stallD=stallE=stallM=1, flushW=1 (a bubble goes into WB).
  - flushD=flushE=0, so the memory freeze overrides hazard stalls.
  - dmem_req held at 1.
- MEM_WAIT transitions:
  - On dmem_ready: return to RUN. This is the last frozen cycle; the pipeline advances on the next edge.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT: set mem_err (cleared only by reset), return to RUN, and release the stalls. The MEM result is undefined.
- dmem_ready outside an access is ignored.
- stall_cnt increments on every edge where stallF=1 and saturates at all-ones.
- Latency:
  - A load-use hazard costs exactly 1 bubble.
  - A branch dependent on EX costs 1 cycle; a branch dependent on a load in MEM costs 1 cycle.
  - A zero-wait memory costs 0 cycles.

Test Plan:
- Load-use: lw $2 in EX (memReadE=1, writeRegE=2, Regfile_weE=1), rsD=2 → stallF=stallD=flushE=1 for 1 cycle; next cycle forwardAE=01 once the load is in WB; stall_cnt=1.
- Forward priority: writeRegM=writeRegW=5, both write enables high, rsE=5 → forwardAE=10. Set rsE=0 with writeRegM=0 → forwardAE=00.
- Branch hazard: branchD=1, rsD=3, Regfile_weE=1, writeRegE=3 → 1 stall cycle. Then writeRegM=3 non-load → forwardAD=1, no stall. With redirectD=1 → flushD=1 only on the non-stalled cycle.
- Memory wait: memAccessM=1, dmem_ready low for 3 cycles then high → dmem_req high for 4 cycles; stallF..stallM and flushW high for 4 cycles; state back to RUN; mem_err=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → release after the counter reaches 4; mem_err=1 and stays 1 until rst=0.
- Async reset mid-wait: drop rst in MEM_WAIT with no clock edge → dmem_req, the stall outputs and stall_cnt go 0 immediately; after release the FSM is in RUN.
